// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator.
//   ST_IDLE / ST_LOAD : FSM state encodings
//   DEF_NOTE_W / DEF_DUR_W : default note and duration widths
//   popcnt8 : population count of up to 8 flags
package voice_allocator_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    localparam int DEF_NOTE_W = 6;
    localparam int DEF_DUR_W  = 6;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/voice_allocator_ffs.sv
// first_free_finder: lowest-index-zero priority encoder over the busy flags.
//   i_busy     : per-voice busy flags
//   o_idx      : index of the lowest voice whose busy flag is 0 (0 if none)
//   o_any_free : at least one voice is free
module first_free_finder #(
    parameter int NUM_VOICES = 3,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_VOICES-1:0] i_busy,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_any_free
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        o_idx      = '0;
        o_any_free = 1'b0;
        for (int k = NUM_VOICES - 1; k >= 0; k--) begin
            if (!i_busy[k]) begin
                o_idx      = IDX_W'(k);
                o_any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator_slot.sv
// voice_allocator_slot: state held for one voice.
//   i_wr        : capture i_note / i_dur (asserted on the accepting edge)
//   i_set       : voice is being loaded this cycle -> becomes busy
//   i_done      : note_player finished -> becomes free
//   i_flush     : synchronous clear of the busy flag (note/duration kept)
//   o_note/o_dur: latched note and duration
//   o_busy      : registered busy flag
//   o_busy_nxt  : value o_busy takes at the next edge (feeds the popcount)
module voice_allocator_slot
    import voice_allocator_pkg::*;
#(
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int DUR_W  = DEF_DUR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_wr,
    input  logic [NOTE_W-1:0] i_note,
    input  logic [DUR_W-1:0]  i_dur,
    input  logic              i_set,
    input  logic              i_done,
    output logic [NOTE_W-1:0] o_note,
    output logic [DUR_W-1:0]  o_dur,
    output logic              o_busy,
    output logic              o_busy_nxt
);

    logic [NOTE_W-1:0] r_note;
    logic [DUR_W-1:0]  r_dur;
    logic              r_busy;
    logic              w_busy_nxt;

    // flush > load > done; a done on an idle voice simply leaves it idle.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_flush)     w_busy_nxt = 1'b0;
        else if (i_set)  w_busy_nxt = 1'b1;
        else if (i_done) w_busy_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_note <= '0;
            r_dur  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (i_wr) begin
                r_note <= i_note;
                r_dur  <= i_dur;
            end
        end
    end

    assign o_note     = r_note;
    assign o_dur      = r_dur;
    assign o_busy     = r_busy;
    assign o_busy_nxt = w_busy_nxt;

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: places note requests from song_reader onto a pool of
// note_player voices. Lowest free voice wins; when all are busy a voice is
// stolen round-robin (STEAL_EN=1) or the request is held off (STEAL_EN=0).
//   clk, reset      : clock, async active-high reset
//   flush           : sync clear of busy state and any grant in flight
//   play            : 0 blocks new grants
//   req_*           : valid/ready note request (note, duration)
//   voice_done      : per-voice done pulses
//   voice_load      : one-hot load pulse, one cycle after the accept
//   voice_note/_duration : per-voice latched values, voice k at [k*W +: W]
//   voice_busy      : per-voice busy flags
//   active_count    : registered popcount of voice_busy
//   stolen          : accompanies voice_load when a busy voice is overwritten
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W,
    parameter int STEAL_EN   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         play,
    input  logic                         req_valid,
    input  logic [NOTE_W-1:0]            req_note,
    input  logic [DUR_W-1:0]             req_duration,
    output logic                         req_ready,
    input  logic [NUM_VOICES-1:0]        voice_done,
    output logic [NUM_VOICES-1:0]        voice_load,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*DUR_W-1:0]  voice_duration,
    output logic [NUM_VOICES-1:0]        voice_busy,
    output logic [3:0]                   active_count,
    output logic                         stolen
);

    localparam int   IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic STEAL = (STEAL_EN != 0);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

    logic [0:0]             r_state;
    logic [IDX_W-1:0]       r_target;
    logic                   r_stolen;
    logic [IDX_W-1:0]       r_steal_ptr;
    logic [3:0]             r_count;

    logic [NUM_VOICES-1:0]  w_busy;
    logic [NUM_VOICES-1:0]  w_busy_nxt;
    logic [NUM_VOICES-1:0]  w_wr;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_any_free;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_in_load;

    // Selection looks only at registered busy, so a done pulse this cycle
    // becomes visible to the allocator one cycle later.
    first_free_finder #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_ffs (
        .i_busy     (w_busy),
        .o_idx      (w_free_idx),
        .o_any_free (w_any_free)
    );

    assign w_pick    = w_any_free ? w_free_idx : r_steal_ptr;
    assign w_ready   = (r_state == ST_IDLE) & play & ~flush & (w_any_free | STEAL);
    assign w_accept  = req_valid & w_ready;
    // flush in the LOAD cycle cancels the pulse; reset clears r_state directly.
    assign w_in_load = (r_state == ST_LOAD) & ~flush;

    genvar k;
    generate
        for (k = 0; k < NUM_VOICES; k++) begin : g_voice
            // Note/duration are captured on the accepting edge so they are
            // already stable when the load pulse is seen.
            assign w_wr[k]       = w_accept & (w_pick == IDX_W'(k));
            assign voice_load[k] = w_in_load & (r_target == IDX_W'(k));

            voice_allocator_slot #(
                .NOTE_W     (NOTE_W),
                .DUR_W      (DUR_W)
            ) u_slot (
                .clk        (clk),
                .reset      (reset),
                .i_flush    (flush),
                .i_wr       (w_wr[k]),
                .i_note     (req_note),
                .i_dur      (req_duration),
                .i_set      (voice_load[k]),
                .i_done     (voice_done[k]),
                .o_note     (voice_note[k*NOTE_W +: NOTE_W]),
                .o_dur      (voice_duration[k*DUR_W +: DUR_W]),
                .o_busy     (w_busy[k]),
                .o_busy_nxt (w_busy_nxt[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_target    <= '0;
            r_stolen    <= 1'b0;
            r_steal_ptr <= '0;
            r_count     <= '0;
        end else begin
            r_count <= popcnt8(8'(w_busy_nxt));
            if (flush) begin
                r_state <= ST_IDLE;
            end else if (w_accept) begin
                r_state     <= ST_LOAD;
                r_target    <= w_pick;
                r_stolen    <= ~w_any_free;
                r_steal_ptr <= (w_pick == LAST) ? '0 : w_pick + 1'b1;
            end else if (r_state == ST_LOAD) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign req_ready    = w_ready;
    assign voice_busy   = w_busy;
    assign active_count = r_count;
    assign stolen       = w_in_load & r_stolen;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        reset;

    // DUT A: STEAL_EN=1
    logic        flush, play, req_valid, req_ready, stolen;
    logic [5:0]  req_note, req_duration;
    logic [2:0]  voice_done, voice_load, voice_busy;
    logic [17:0] voice_note, voice_duration;
    logic [3:0]  active_count;

    // DUT B: STEAL_EN=0
    logic        b_flush, b_play, b_req_valid, b_req_ready, b_stolen;
    logic [5:0]  b_req_note, b_req_duration;
    logic [2:0]  b_voice_done, b_voice_load, b_voice_busy;
    logic [17:0] b_voice_note, b_voice_duration;
    logic [3:0]  b_active_count;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .STEAL_EN(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .play(play),
        .req_valid(req_valid), .req_note(req_note), .req_duration(req_duration),
        .req_ready(req_ready), .voice_done(voice_done), .voice_load(voice_load),
        .voice_note(voice_note), .voice_duration(voice_duration),
        .voice_busy(voice_busy), .active_count(active_count), .stolen(stolen)
    );

    voice_allocator #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .STEAL_EN(0)) dut_b (
        .clk(clk), .reset(reset), .flush(b_flush), .play(b_play),
        .req_valid(b_req_valid), .req_note(b_req_note), .req_duration(b_req_duration),
        .req_ready(b_req_ready), .voice_done(b_voice_done), .voice_load(b_voice_load),
        .voice_note(b_voice_note), .voice_duration(b_voice_duration),
        .voice_busy(b_voice_busy), .active_count(b_active_count), .stolen(b_stolen)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request on A in IDLE, take the accepting edge, drop valid.
    // Returns in the LOAD cycle.
    task automatic send_a(input logic [5:0] n, input logic [5:0] d);
        req_valid = 1'b1; req_note = n; req_duration = d;
        step();
        req_valid = 1'b0;
        #1;
    endtask

    task automatic send_b(input logic [5:0] n, input logic [5:0] d);
        b_req_valid = 1'b1; b_req_note = n; b_req_duration = d;
        step();
        b_req_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 0; play = 0; req_valid = 0; req_note = 0; req_duration = 0; voice_done = 0;
        b_flush = 0; b_play = 0; b_req_valid = 0; b_req_note = 0; b_req_duration = 0; b_voice_done = 0;
        step(); step();
        vecs++;
        if (voice_load !== 3'b000 || voice_busy !== 3'b000 || active_count !== 4'd0 ||
            stolen !== 1'b0 || req_ready !== 1'b0 || voice_note !== 18'd0 || voice_duration !== 18'd0) begin
            errs++;
            $display("FAIL reset_state: load=%b busy=%b cnt=%0d stolen=%b ready=%b note=%h dur=%h, required all zero",
                     voice_load, voice_busy, active_count, stolen, req_ready, voice_note, voice_duration);
        end
        reset = 1'b0;
        step();
        play = 1'b1; b_play = 1'b1;
        #1;
        vecs++;
        if (req_ready !== 1'b1) begin
            errs++; $display("FAIL ready_after_reset: got %b required 1", req_ready);
        end
    endtask

    task automatic test_fill();
        logic [2:0] e;
        for (int i = 0; i < 3; i++) begin
            e = 3'b001 << i;
            send_a(6'(10 * (i + 1)), 6'd4);
            vecs++;
            if (voice_load !== e || stolen !== 1'b0 || req_ready !== 1'b0 ||
                voice_note[i*6 +: 6] !== 6'(10 * (i + 1)) || voice_duration[i*6 +: 6] !== 6'd4) begin
                errs++;
                $display("FAIL fill_load%0d: load=%b stolen=%b ready=%b note=%0d dur=%0d, required load=%b stolen=0 ready=0 note=%0d dur=4",
                         i, voice_load, stolen, req_ready, voice_note[i*6 +: 6], voice_duration[i*6 +: 6], e, 10 * (i + 1));
            end
            step();
            vecs++;
            if (voice_load !== 3'b000 || active_count !== 4'(i + 1)) begin
                errs++;
                $display("FAIL fill_idle%0d: load=%b cnt=%0d, required load=000 cnt=%0d", i, voice_load, active_count, i + 1);
            end
        end
        vecs++;
        if (voice_busy !== 3'b111 || active_count !== 4'd3 || req_ready !== 1'b1) begin
            errs++;
            $display("FAIL fill_full: busy=%b cnt=%0d ready=%b, required busy=111 cnt=3 ready=1", voice_busy, active_count, req_ready);
        end
    endtask

    task automatic test_steal();
        send_a(6'd40, 6'd7);
        vecs++;
        if (voice_load !== 3'b001 || stolen !== 1'b1 || voice_note[5:0] !== 6'd40) begin
            errs++;
            $display("FAIL steal_first: load=%b stolen=%b note0=%0d, required load=001 stolen=1 note0=40", voice_load, stolen, voice_note[5:0]);
        end
        step();
        send_a(6'd41, 6'd7);
        vecs++;
        if (voice_load !== 3'b010 || stolen !== 1'b1 || voice_note[11:6] !== 6'd41) begin
            errs++;
            $display("FAIL steal_second: load=%b stolen=%b note1=%0d, required load=010 stolen=1 note1=41", voice_load, stolen, voice_note[11:6]);
        end
        step();
        send_a(6'd42, 6'd1);
        vecs++;
        if (voice_load !== 3'b100 || stolen !== 1'b1) begin
            errs++;
            $display("FAIL steal_wrap: load=%b stolen=%b, required load=100 stolen=1", voice_load, stolen);
        end
        step();
        vecs++;
        if (voice_busy !== 3'b111 || active_count !== 4'd3) begin
            errs++;
            $display("FAIL steal_busy: busy=%b cnt=%0d, required busy=111 cnt=3", voice_busy, active_count);
        end
    endtask

    task automatic test_done_vs_load();
        // steal pointer has wrapped back to voice 0
        send_a(6'd43, 6'd2);
        voice_done = 3'b001;
        #1;
        vecs++;
        if (voice_load !== 3'b001) begin
            errs++; $display("FAIL dvl_load: load=%b required 001", voice_load);
        end
        step();
        voice_done = 3'b000;
        #1;
        vecs++;
        if (voice_busy !== 3'b111 || active_count !== 4'd3) begin
            errs++;
            $display("FAIL dvl_busy: busy=%b cnt=%0d, required busy=111 cnt=3", voice_busy, active_count);
        end
        voice_done = 3'b010;
        step();
        voice_done = 3'b000;
        #1;
        vecs++;
        if (voice_busy !== 3'b101 || active_count !== 4'd2) begin
            errs++;
            $display("FAIL done_clear: busy=%b cnt=%0d, required busy=101 cnt=2", voice_busy, active_count);
        end
    endtask

    task automatic test_play_gate();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        vecs++;
        if (voice_busy !== 3'b000 || active_count !== 4'd0 || voice_load !== 3'b000) begin
            errs++;
            $display("FAIL flush_idle: busy=%b cnt=%0d load=%b, required 000 0 000", voice_busy, active_count, voice_load);
        end
        voice_done = 3'b111;   // done on idle voices must be ignored
        step();
        voice_done = 3'b000;
        #1;
        vecs++;
        if (voice_busy !== 3'b000 || active_count !== 4'd0) begin
            errs++;
            $display("FAIL done_idle: busy=%b cnt=%0d, required 000 0", voice_busy, active_count);
        end
        play = 1'b0;
        req_valid = 1'b1; req_note = 6'd50; req_duration = 6'd9;
        for (int i = 0; i < 20; i++) begin
            step();
            vecs++;
            if (voice_load !== 3'b000 || req_ready !== 1'b0) begin
                errs++;
                $display("FAIL paused_c%0d: load=%b ready=%b, required 000 0", i, voice_load, req_ready);
            end
        end
        play = 1'b1;
        #1;
        vecs++;
        if (req_ready !== 1'b1) begin
            errs++; $display("FAIL resume_ready: got %b required 1", req_ready);
        end
        step();
        req_valid = 1'b0;
        #1;
        vecs++;
        if (voice_load !== 3'b001 || stolen !== 1'b0 || voice_note[5:0] !== 6'd50 || voice_duration[5:0] !== 6'd9) begin
            errs++;
            $display("FAIL resume_load: load=%b stolen=%b note0=%0d dur0=%0d, required 001 0 50 9",
                     voice_load, stolen, voice_note[5:0], voice_duration[5:0]);
        end
        step();
        // pausing during LOAD still lets the grant complete
        send_a(6'd51, 6'd3);
        play = 1'b0;
        #1;
        vecs++;
        if (voice_load !== 3'b010) begin
            errs++; $display("FAIL pause_in_load: load=%b required 010", voice_load);
        end
        step();
        play = 1'b1;
        #1;
        vecs++;
        if (voice_busy !== 3'b011 || active_count !== 4'd2) begin
            errs++;
            $display("FAIL pause_busy: busy=%b cnt=%0d, required 011 2", voice_busy, active_count);
        end
    endtask

    task automatic test_flush_in_load();
        send_a(6'd52, 6'd5);
        flush = 1'b1;
        #1;
        vecs++;
        if (voice_load !== 3'b000 || stolen !== 1'b0) begin
            errs++; $display("FAIL flush_load: load=%b stolen=%b, required 000 0", voice_load, stolen);
        end
        step();
        flush = 1'b0;
        #1;
        vecs++;
        if (voice_busy !== 3'b000 || active_count !== 4'd0 || voice_load !== 3'b000 ||
            req_ready !== 1'b1 || voice_note[5:0] !== 6'd50) begin
            errs++;
            $display("FAIL flush_after: busy=%b cnt=%0d load=%b ready=%b note0=%0d, required 000 0 000 1 50",
                     voice_busy, active_count, voice_load, req_ready, voice_note[5:0]);
        end
    endtask

    task automatic test_no_steal();
        for (int i = 0; i < 3; i++) begin
            send_b(6'(60 + i), 6'd2);
            step();
        end
        vecs++;
        if (b_voice_busy !== 3'b111 || b_active_count !== 4'd3) begin
            errs++;
            $display("FAIL nosteal_fill: busy=%b cnt=%0d, required 111 3", b_voice_busy, b_active_count);
        end
        b_req_valid = 1'b1; b_req_note = 6'd63; b_req_duration = 6'd8;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++;
            if (b_req_ready !== 1'b0 || b_voice_load !== 3'b000) begin
                errs++;
                $display("FAIL nosteal_hold%0d: ready=%b load=%b, required 0 000", i, b_req_ready, b_voice_load);
            end
            step();
        end
        b_voice_done = 3'b010;
        #1;
        vecs++;
        if (b_req_ready !== 1'b0) begin
            errs++; $display("FAIL nosteal_done_same: ready=%b required 0", b_req_ready);
        end
        step();
        b_voice_done = 3'b000;
        #1;
        vecs++;
        if (b_req_ready !== 1'b1) begin
            errs++; $display("FAIL nosteal_done_next: ready=%b required 1", b_req_ready);
        end
        step();
        b_req_valid = 1'b0;
        #1;
        vecs++;
        if (b_voice_load !== 3'b010 || b_stolen !== 1'b0 || b_voice_note[11:6] !== 6'd63) begin
            errs++;
            $display("FAIL nosteal_grant: load=%b stolen=%b note1=%0d, required 010 0 63", b_voice_load, b_stolen, b_voice_note[11:6]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_steal();
        test_done_vs_load();
        test_play_gate();
        test_flush_in_load();
        test_no_steal();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
